// File: rtl/mem_ram_sync_gen.sv
// Synchronous dual-port (1W/1R) RAM with byte enables, self-clearing after reset,
// configurable read latency (1 or 2) and read-during-write behaviour.
module mem_ram_sync_gen #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1,
    parameter bit RDW_NEW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_rq,
    input  logic [ADDR_W-1:0]     wr_address,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   write_be,
    input  logic                  read_rq,
    input  logic [ADDR_W-1:0]     rd_address,
    output logic [DATA_W-1:0]     read_data,
    output logic                  read_valid,
    output logic                  init_busy,
    output logic                  req_dropped
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, READY} state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   cnt, next_cnt;
    logic                do_wr, do_rd, drop;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   wr_merged, rd_word;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++)
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // INIT stops at the last address instead of wrapping; requests seen there are dropped.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        init_busy  = 1'b0;
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        drop       = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                drop      = read_rq | write_rq;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    next_state = READY;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            READY: begin
                do_wr = write_rq;
                do_rd = read_rq;
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       req_dropped <= 1'b0;
        else if (drop) req_dropped <= 1'b1;
    end

    assign wr_merged = merge(mem[wr_address], write_data, write_be);

    // Same-address bypass: forward the merged word when new-data semantics are selected.
    always_comb begin
        rd_word = mem[rd_address];
        if (RDW_NEW && do_wr && (wr_address == rd_address))
            rd_word = wr_merged;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[cnt] <= '0;
            else if (do_wr)
                mem[wr_address] <= wr_merged;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    read_valid <= 1'b0;
                    read_data  <= '0;
                end else begin
                    read_valid <= do_rd;
                    if (do_rd) read_data <= rd_word;
                end
            end
        end else begin : g_lat2
            logic              s1_vld;
            logic [DATA_W-1:0] s1_data;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld     <= 1'b0;
                    s1_data    <= '0;
                    read_valid <= 1'b0;
                    read_data  <= '0;
                end else begin
                    s1_vld     <= do_rd;
                    if (do_rd) s1_data <= rd_word;
                    read_valid <= s1_vld;
                    if (s1_vld) read_data <= s1_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_ram_sync_gen.sv
// Directed self-checking bench for mem_ram_sync_gen: init clear, byte enables,
// read-during-write, streaming reads, dropped requests and mid-init reset.
module tb_mem_ram_sync_gen;

    localparam int    DATA_W   = 16;
    localparam int    ADDR_W   = 6;
    localparam int    READ_LAT = 1;
    localparam bit    RDW_NEW  = 1'b0;

    logic              clk = 1'b0;
    logic              rst;
    logic              write_rq;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] write_data;
    logic [1:0]        write_be;
    logic              read_rq;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              init_busy;
    logic              req_dropped;

    int total = 0;
    int bad   = 0;

    mem_ram_sync_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .RDW_NEW(RDW_NEW)
    ) dut (
        .clk(clk), .rst(rst),
        .write_rq(write_rq), .wr_address(wr_address), .write_data(write_data), .write_be(write_be),
        .read_rq(read_rq), .rd_address(rd_address),
        .read_data(read_data), .read_valid(read_valid),
        .init_busy(init_busy), .req_dropped(req_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] be);
        write_rq = 1'b1; wr_address = a; write_data = d; write_be = be;
        tick();
        write_rq = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
        read_rq = 1'b1; rd_address = a;
        tick();
        read_rq = 1'b0;
        for (int i = 1; i < READ_LAT; i++) begin
            chk({tag, "_early"}, 32'(read_valid), 32'd0);
            tick();
        end
        chk({tag, "_vld"}, 32'(read_valid), 32'd1);
        chk({tag, "_data"}, 32'(read_data), 32'(exp));
        tick();
        chk({tag, "_pulse"}, 32'(read_valid), 32'd0);
        chk({tag, "_hold"}, 32'(read_data), 32'(exp));
    endtask

    // Counts INIT cycles after the reset edge; flags any read_valid seen meanwhile.
    task automatic run_init(input string tag, input bit drop_wr);
        int n;
        int vld_seen;
        n = 0; vld_seen = 0;
        while (init_busy === 1'b1 && n < 200) begin
            if (drop_wr && n == 10) begin
                write_rq = 1'b1; wr_address = 6'd3; write_data = 16'hFFFF; write_be = 2'b11;
                read_rq = 1'b1; rd_address = 6'd3;
            end
            tick();
            write_rq = 1'b0; read_rq = 1'b0;
            if (read_valid === 1'b1) vld_seen++;
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'd64);
        chk({tag, "_novld"}, 32'(vld_seen), 32'd0);
    endtask

    initial begin
        int vcnt;
        rst = 1'b1; write_rq = 1'b0; read_rq = 1'b0;
        wr_address = '0; rd_address = '0; write_data = '0; write_be = '0;
        tick();
        tick();
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_vld", 32'(read_valid), 32'd0);
        chk("rst_data", 32'(read_data), 32'd0);
        chk("rst_drop", 32'(req_dropped), 32'd0);

        rst = 1'b0;
        run_init("init1", 1'b1);
        chk("drop_flag", 32'(req_dropped), 32'd1);

        rd(6'd0, 16'h0000, "clr0");
        rd(6'd31, 16'h0000, "clr31");
        rd(6'd63, 16'h0000, "clr63");
        rd(6'd3, 16'h0000, "drop_mem3");
        chk("drop_sticky", 32'(req_dropped), 32'd1);

        wr(6'd5, 16'hABCD, 2'b11);
        wr(6'd5, 16'h1200, 2'b10);
        rd(6'd5, 16'h12CD, "be_hi");
        wr(6'd5, 16'hFFFF, 2'b00);
        rd(6'd5, 16'h12CD, "be_none");
        wr(6'd6, 16'hABCD, 2'b01);
        rd(6'd6, 16'h00CD, "be_lo");

        wr(6'd9, 16'h1111, 2'b11);
        write_rq = 1'b1; wr_address = 6'd9; write_data = 16'h2222; write_be = 2'b11;
        read_rq = 1'b1; rd_address = 6'd9;
        tick();
        write_rq = 1'b0; read_rq = 1'b0;
        for (int i = 1; i < READ_LAT; i++) tick();
        chk("rdw_vld", 32'(read_valid), 32'd1);
        chk("rdw_data", 32'(read_data), RDW_NEW ? 32'h2222 : 32'h1111);
        rd(6'd9, 16'h2222, "rdw_after");

        write_rq = 1'b1; wr_address = 6'd10; write_data = 16'h3333; write_be = 2'b11;
        read_rq = 1'b1; rd_address = 6'd5;
        tick();
        write_rq = 1'b0; read_rq = 1'b0;
        for (int i = 1; i < READ_LAT; i++) tick();
        chk("diff_rd", 32'(read_data), 32'h12CD);
        rd(6'd10, 16'h3333, "diff_wr");

        for (int i = 0; i < 8; i++) wr(ADDR_W'(i), DATA_W'(i), 2'b11);
        vcnt = 0;
        for (int t = 1; t <= 8 + READ_LAT; t++) begin
            read_rq = (t <= 8); rd_address = ADDR_W'(t - 1);
            tick();
            read_rq = 1'b0;
            if (t >= READ_LAT && t < READ_LAT + 8) begin
                if (read_valid === 1'b1 && read_data === DATA_W'(t - READ_LAT)) vcnt++;
            end else begin
                chk("strm_idle", 32'(read_valid), 32'd0);
            end
        end
        chk("strm_cnt", 32'(vcnt), 32'd8);

        // Read and reset on the same edge: the read must vanish.
        read_rq = 1'b1; rd_address = 6'd5; rst = 1'b1;
        tick();
        read_rq = 1'b0; rst = 1'b0;
        chk("rrd_vld", 32'(read_valid), 32'd0);
        chk("rrd_data", 32'(read_data), 32'd0);
        chk("rrd_busy", 32'(init_busy), 32'd1);
        chk("rrd_drop", 32'(req_dropped), 32'd0);
        repeat (40) tick();
        chk("mid_busy", 32'(init_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_init("init2", 1'b0);
        chk("init2_drop", 32'(req_dropped), 32'd0);
        rd(6'd5, 16'h0000, "reclr5");
        rd(6'd9, 16'h0000, "reclr9");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ram_sync_gen.md
MEM_RAM_SYNC_GEN -- requirements
Module: mem_ram_sync_gen

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: data word width in bits; multiple of 8, minimum 8.
REQ-002 SHALL provide parameter ADDR_W, default 6: address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter READ_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL provide parameter RDW_NEW, default 0: read-during-write data; 0 = old data, 1 = new data.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port write_rq  input  1  write request.
REQ-008 SHALL have port wr_address  input  ADDR_W  write address.
REQ-009 SHALL have port write_data  input  DATA_W  write data.
REQ-010 SHALL have port write_be  input  DATA_W/8  byte enables; bit k covers write_data[8k+7:8k].
REQ-011 SHALL have port read_rq  input  1  read request.
REQ-012 SHALL have port rd_address  input  ADDR_W  read address.
REQ-013 SHALL have port read_data  output  DATA_W  read data.
REQ-014 SHALL have port read_valid  output  1  one-cycle pulse marking read_data valid.
REQ-015 SHALL have port init_busy  output  1  high while memory clear is in progress.
REQ-016 SHALL have port req_dropped  output  1  sticky flag: a request arrived while init_busy.

Function
REQ-017 SHALL implement a two-state FSM: INIT and READY.
REQ-018 INIT SHALL write zero to one word per cycle, address counter 0 to DEPTH-1, then enter READY on the cycle after word DEPTH-1 is written.
REQ-019 init_busy SHALL equal 1 exactly while in INIT; INIT lasts DEPTH cycles.
REQ-020 In READY, write_rq=1 SHALL update only the bytes of mem[wr_address] whose write_be bit is 1; write_be=0 leaves the word unchanged.
REQ-021 In READY, read_rq=1 SHALL produce mem[rd_address] on read_data, with read_valid=1, exactly READ_LAT cycles after the request edge.
REQ-022 READ_LAT=2 SHALL add one output register stage; both stages advance every cycle, with no backpressure.
REQ-023 read_data SHALL hold its last value when no read completes; read_valid SHALL be 0 in those cycles.
REQ-024 Back-to-back reads SHALL be accepted every cycle, giving one read_valid per read_rq.
REQ-025 Simultaneous read and write with rd_address==wr_address SHALL return the pre-write word if RDW_NEW=0, or the post-write merged word (byte enables applied) if RDW_NEW=1.
REQ-026 Simultaneous read and write to different addresses SHALL both complete with no interaction.
REQ-027 read_rq or write_rq asserted in INIT SHALL be ignored: no memory update, no read_valid. req_dropped SHALL be set to 1 and held until reset.
REQ-028 Address counter wrap SHALL NOT occur; INIT SHALL terminate at DEPTH-1.

Reset
REQ-029 rst=1 at a clock edge SHALL force INIT with counter 0, read_data=0, read_valid=0, req_dropped=0, and flush the read pipeline; init_busy SHALL read 1 from that edge.
REQ-030 rst asserted mid-INIT or mid-read SHALL restart clearing from address 0; reads in flight SHALL be discarded, with no read_valid.
REQ-031 Memory clear SHALL complete DEPTH cycles after the last cycle with rst=1.

Verification
REQ-032 Reset/init: pulse rst 1 cycle -> init_busy=1 for 64 cycles then 0; reads of addresses 0, 31, 63 -> 0x0000.
REQ-033 Byte enables: write 0xABCD to addr 5 with be=11, then 0x1200 with be=10; read addr 5 -> 0x12CD, read_valid pulses 1 cycle after the request (READ_LAT=1) or 2 cycles after (READ_LAT=2).
REQ-034 Read-during-write: mem[9]=0x1111; write 0x2222 with be=11 and read, both at addr 9 in the same cycle -> 0x1111 (RDW_NEW=0) or 0x2222 (RDW_NEW=1).
REQ-035 Streaming: read addresses 0..7 on consecutive cycles after writing mem[i]=i -> 8 consecutive read_valid pulses with data 0..7 in order.
REQ-036 Request during INIT: write 0xFFFF to addr 3 at cycle 10 of INIT -> req_dropped=1; after INIT, mem[3]=0x0000.
REQ-037 Reset mid-operation: assert rst at INIT cycle 40 -> init_busy stays 1 for 64 more cycles, with no read_valid in that period.
